slave_mem_responder: RTL and testbench

//  Module-side responder for a bus slave. It sits behind the slave's parallel module interface
//  and stands in for the attached peripheral.
//  It consumes the slave's write-enable and read-request strobes and services them from a local

---
 rtl/slave_mem_responder.sv | 129 ++++++++++++
 tb/tb_slave_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/slave_mem_responder.sv
// Module-side stand-in for a bus slave's peripheral: services write/read strobes from a local
// register array and acknowledges each with a one-cycle module_dv pulse after a fixed latency.
module slave_mem_responder #(
  parameter int unsigned ADDRESS_WIDTH = 15,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MEM_ADDR_BITS = 4,
  parameter int unsigned WR_LATENCY    = 2,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_strobe,
  input  logic                     rd_strobe,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     module_dv,
  output logic                     busy,
  output logic                     req_dropped
);

  localparam int unsigned MaxLat = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam int unsigned Depth  = 1 << MEM_ADDR_BITS;
  localparam logic [CntW-1:0] WrCnt = CntW'(WR_LATENCY - 1);
  localparam logic [CntW-1:0] RdCnt = CntW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWrWait, StRdWait, StAck} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    wr_prev_q, rd_prev_q;
  logic [DATA_WIDTH-1:0]   rd_buf_q, rd_buf_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    dv_q, dv_d;
  logic                    busy_q, busy_d;
  logic                    drop_q, drop_d;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_q [Depth];
  logic [MEM_ADDR_BITS-1:0] idx;
  logic                    wr_edge, rd_edge;

  // Upper address bits are intentionally ignored so that addresses alias modulo the depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_in[ADDRESS_WIDTH-1:MEM_ADDR_BITS];

  assign idx     = addr_in[MEM_ADDR_BITS-1:0];
  assign wr_edge = wr_strobe & ~wr_prev_q;
  assign rd_edge = rd_strobe & ~rd_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_buf_d  = rd_buf_q;
    rd_data_d = rd_data_q;
    dv_d      = 1'b0;
    busy_d    = busy_q;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_edge) begin
          // A simultaneous read edge loses to the write.
          mem_we  = 1'b1;
          cnt_d   = WrCnt;
          state_d = StWrWait;
          busy_d  = 1'b1;
          drop_d  = rd_edge;
        end else if (rd_edge) begin
          rd_buf_d = mem_q[idx];
          cnt_d    = RdCnt;
          state_d  = StRdWait;
          busy_d   = 1'b1;
        end
      end
      StWrWait, StRdWait: begin
        drop_d = wr_edge | rd_edge;
        if (cnt_q == '0) begin
          state_d = StAck;
          dv_d    = 1'b1;
          if (state_q == StRdWait) rd_data_d = rd_buf_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAck: begin
        drop_d  = wr_edge | rd_edge;
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      rd_buf_q  <= '0;
      rd_data_q <= '0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_prev_q <= wr_strobe;
      rd_prev_q <= rd_strobe;
      rd_buf_q  <= rd_buf_d;
      rd_data_q <= rd_data_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && rstn) mem_q[idx] <= wr_data;
  end

  assign rd_data     = rd_data_q;
  assign module_dv   = dv_q;
  assign busy        = busy_q;
  assign req_dropped = drop_q;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Scoreboard bench for slave_mem_responder: directed strobes push expected acknowledges and drops;
// independent monitors pop and compare whenever module_dv or req_dropped is seen.
module tb_slave_mem_responder;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int WL = 2;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          wr_strobe = 1'b0;
  logic          rd_strobe = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          module_dv;
  logic          busy;
  logic          req_dropped;

  slave_mem_responder #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .MEM_ADDR_BITS(4),
    .WR_LATENCY   (WL),
    .RD_LATENCY   (RL)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_strobe  (wr_strobe),
    .rd_strobe  (rd_strobe),
    .addr_in    (addr_in),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .module_dv  (module_dv),
    .busy       (busy),
    .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            is_rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Acknowledge monitor
  always @(negedge clk) begin
    exp_t e;
    if (module_dv === 1'b1) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_dv (cycle %0d): got module_dv=1, expected 0", cyc);
      end else begin
        e = exp_q.pop_front();
        check("dv_cycle", cyc, e.cyc);
        if (e.is_rd) check("rd_data_at_dv", 32'(rd_data), 32'(e.data));
      end
    end
  end

  // Drop monitor
  always @(negedge clk) begin
    int c;
    if (req_dropped === 1'b1) begin
      if (drop_q.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_drop (cycle %0d): got req_dropped=1, expected 0", cyc);
      end else begin
        c = drop_q.pop_front();
        check("drop_cycle", cyc, c);
      end
    end
  end

  task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr_in   = a;
    wr_data   = d;
    wr_strobe = 1'b1;
    exp_q.push_back('{cyc: cyc + 1 + WL, is_rd: 1'b0, data: '0});
    @(negedge clk);
    wr_strobe = 1'b0;
  endtask

  task automatic start_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr_in   = a;
    rd_strobe = 1'b1;
    exp_q.push_back('{cyc: cyc + 1 + RL, is_rd: 1'b1, data: d});
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (exp_q.size() != 0 || drop_q.size() != 0); i++) @(negedge clk);
    check("drain_dv_queue", exp_q.size(), 0);
    check("drain_drop_queue", drop_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // 1: reset at an arbitrary phase, held over two clocks
    #3 rstn = 1'b0;
    #24 rstn = 1'b1;
    @(negedge clk);
    check("reset_rd_data", 32'(rd_data), 0);
    check("reset_module_dv", 32'(module_dv), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_req_dropped", 32'(req_dropped), 0);

    // 2: write 203 at 21845 with busy profile 1,1,1,0
    @(negedge clk);
    addr_in   = AW'(21845);
    wr_data   = 8'd203;
    wr_strobe = 1'b1;
    exp_q.push_back('{cyc: cyc + 1 + WL, is_rd: 1'b0, data: '0});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) wr_strobe = 1'b0;
      check("busy_write", 32'(busy), (i <= 3) ? 1 : 0);
    end
    drain();

    // 3: read back, then rd_data held
    start_read(AW'(21845), 8'd203);
    drain();
    check("rd_data_held", 32'(rd_data), 203);

    // 4: aliasing through ignored upper address bits
    start_read(AW'(5), 8'd203);
    drain();
    start_write(AW'(21), 8'd224);
    drain();
    check("write_keeps_rd_data", 32'(rd_data), 203);
    start_read(AW'(21845), 8'd224);
    drain();

    // 5a: simultaneous edges: write wins, read dropped
    @(negedge clk);
    addr_in   = AW'(3);
    wr_data   = 8'd17;
    wr_strobe = 1'b1;
    rd_strobe = 1'b1;
    exp_q.push_back('{cyc: cyc + 1 + WL, is_rd: 1'b0, data: '0});
    drop_q.push_back(cyc + 1);
    @(negedge clk);
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    drain();
    check("collision_no_rd_change", 32'(rd_data), 224);

    // 5b: read edge during WR_WAIT is dropped, no extra acknowledge
    @(negedge clk);
    addr_in   = AW'(9);
    wr_data   = 8'd66;
    wr_strobe = 1'b1;
    exp_q.push_back('{cyc: cyc + 1 + WL, is_rd: 1'b0, data: '0});
    @(negedge clk);
    wr_strobe = 1'b0;
    rd_strobe = 1'b1;
    drop_q.push_back(cyc + 1);
    @(negedge clk);
    rd_strobe = 1'b0;
    drain();

    // Back-to-back: read edge on the first IDLE cycle after ACK is accepted
    @(negedge clk);
    addr_in   = AW'(9);
    wr_data   = 8'd77;
    wr_strobe = 1'b1;
    exp_q.push_back('{cyc: cyc + 1 + WL, is_rd: 1'b0, data: '0});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      wr_strobe = 1'b0;
    end
    @(negedge clk);
    rd_strobe = 1'b1;
    exp_q.push_back('{cyc: cyc + 1 + RL, is_rd: 1'b1, data: 8'd77});
    @(negedge clk);
    rd_strobe = 1'b0;
    drain();

    // 6: reset during RD_WAIT aborts the read; array survives
    @(negedge clk);
    addr_in   = AW'(3);
    rd_strobe = 1'b1;
    @(negedge clk);
    check("busy_rd_wait", 32'(busy), 1);
    rstn      = 1'b0;
    rd_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_rd_data", 32'(rd_data), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_module_dv", 32'(module_dv), 0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    start_read(AW'(3), 8'd17);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
